vector_alu_sequencer: RTL and testbench

VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

---
 rtl/vector_alu_sequencer_if.sv | 67 ++++++
 rtl/vector_alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_vector_alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_alu_sequencer_if.sv
// Command, register-file, ALU and status signals of the vector ALU sequencer.
// Latency: none, wires only; timing is set by the sequencer that drives it.
// Backpressure: commands are held off by o_ready; the other groups have no flow control.
interface vector_alu_sequencer_if #(
    parameter int VLEN = 128
);
    localparam int NW = VLEN / 32;
    localparam int AW = 5 + $clog2(NW);

    // command handshake and fields
    logic              i_valid;
    logic              o_ready;
    logic [5:0]        i_funct6;
    logic [4:0]        i_vs1;
    logic [4:0]        i_vs2;
    logic [4:0]        i_vd;
    logic [1:0]        i_sew;
    logic [7:0]        i_vl;
    logic              i_vm;
    logic [VLEN/8-1:0] i_v0;

    // register file read ports
    logic [AW-1:0]     o_rs1_addr;
    logic [AW-1:0]     o_rs2_addr;
    logic [31:0]       i_rs1_data;
    logic [31:0]       i_rs2_data;

    // ALU operands and control
    logic [31:0]       o_alu_in1;
    logic [31:0]       o_alu_in2;
    logic [5:0]        o_alu_funct6;
    logic              o_alu_8bits;
    logic              o_alu_16bits;
    logic [3:0]        o_alu_masks;
    logic [31:0]       i_alu_result;
    logic              i_alu_is_sat;

    // register file write port
    logic              o_rf_we;
    logic [AW-1:0]     o_rf_waddr;
    logic [31:0]       o_rf_wdata;
    logic [3:0]        o_rf_wbe;

    // completion and status
    logic              o_done;
    logic              o_illegal;
    logic              o_vxsat;
    logic              i_vxsat_clr;

    modport slave (
        input  i_valid, i_funct6, i_vs1, i_vs2, i_vd, i_sew, i_vl, i_vm, i_v0,
        input  i_rs1_data, i_rs2_data, i_alu_result, i_alu_is_sat, i_vxsat_clr,
        output o_ready, o_rs1_addr, o_rs2_addr,
        output o_alu_in1, o_alu_in2, o_alu_funct6, o_alu_8bits, o_alu_16bits, o_alu_masks,
        output o_rf_we, o_rf_waddr, o_rf_wdata, o_rf_wbe,
        output o_done, o_illegal, o_vxsat
    );

    modport master (
        output i_valid, i_funct6, i_vs1, i_vs2, i_vd, i_sew, i_vl, i_vm, i_v0,
        output i_rs1_data, i_rs2_data, i_alu_result, i_alu_is_sat, i_vxsat_clr,
        input  o_ready, o_rs1_addr, o_rs2_addr,
        input  o_alu_in1, o_alu_in2, o_alu_funct6, o_alu_8bits, o_alu_16bits, o_alu_masks,
        input  o_rf_we, o_rf_waddr, o_rf_wdata, o_rf_wbe,
        input  o_done, o_illegal, o_vxsat
    );
endinterface

// File: rtl/vector_alu_sequencer.sv
// Sequences one vector ALU command word by word: read operands, run ALU, write masked result.
// Latency: word k written 2k+2 cycles after acceptance, o_done at 2N+1 (1 for empty/illegal).
// Backpressure: o_ready only in IDLE; a command is held off until the previous one completes.
module vector_alu_sequencer #(
    parameter int VLEN = 128
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    vector_alu_sequencer_if.slave  bus
);
    localparam int NW = VLEN / 32;
    localparam int WB = $clog2(NW);
    localparam int EB = WB + 2;

    typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

    state_t            state_q;
    logic [WB-1:0]     k_q;
    logic [5:0]        funct6_q;
    logic [4:0]        vs1_q;
    logic [4:0]        vs2_q;
    logic [4:0]        vd_q;
    logic [1:0]        sew_q;
    logic              vm_q;
    logic [VLEN/8-1:0] v0_q;
    logic [7:0]        vl_q;
    logic [7:0]        n_q;
    logic              ready_q;
    logic              done_q;
    logic              illegal_q;
    logic              vxsat_q;
    logic              vxsat_d;

    logic              accept;
    logic [7:0]        vlmax;
    logic [7:0]        vl_eff;
    logic [7:0]        n_words;
    logic [EB-1:0]     e;
    logic [3:0]        lane_en;
    logic              last_word;
    logic              we;

    // Element that owns byte lane 'lane' of word k for the given element width.
    function automatic logic [EB-1:0] elem_idx(input logic [1:0] sew,
                                               input logic [WB-1:0] k,
                                               input logic [1:0] lane);
        case (sew)
            2'b00:   return {k, lane};
            2'b01:   return {1'b0, k, lane[1]};
            default: return {2'b00, k};
        endcase
    endfunction

    assign accept = bus.i_valid & ready_q;

    // Clamp the requested length to the register capacity and derive the word count.
    always_comb begin
        case (bus.i_sew)
            2'b00:   vlmax = 8'(VLEN / 8);
            2'b01:   vlmax = 8'(VLEN / 16);
            default: vlmax = 8'(VLEN / 32);
        endcase
        vl_eff = (bus.i_vl < vlmax) ? bus.i_vl : vlmax;
        case (bus.i_sew)
            2'b00:   n_words = (vl_eff + 8'd3) >> 2;
            2'b01:   n_words = (vl_eff + 8'd1) >> 1;
            default: n_words = vl_eff;
        endcase
    end

    // Byte-lane enables of the current word: element inside vl and not masked off.
    always_comb begin
        e       = '0;
        lane_en = '0;
        for (int j = 0; j < 4; j++) begin
            e          = elem_idx(sew_q, k_q, 2'(j));
            lane_en[j] = (8'(e) < vl_q) && (vm_q || v0_q[e]);
        end
    end

    // A write in the reset cycle is suppressed so an aborted command leaves no trace.
    assign we        = (state_q == EXEC) && (|lane_en) && !i_rst;
    assign last_word = (8'(k_q) == n_q - 8'd1);

    assign bus.o_ready      = ready_q;
    assign bus.o_rs1_addr   = {vs1_q, k_q};
    assign bus.o_rs2_addr   = {vs2_q, k_q};
    assign bus.o_alu_in1    = bus.i_rs2_data;
    assign bus.o_alu_in2    = bus.i_rs1_data;
    assign bus.o_alu_funct6 = funct6_q;
    assign bus.o_alu_8bits  = (sew_q == 2'b00);
    assign bus.o_alu_16bits = (sew_q == 2'b01);
    assign bus.o_alu_masks  = lane_en;
    assign bus.o_rf_we      = we;
    assign bus.o_rf_waddr   = {vd_q, k_q};
    assign bus.o_rf_wdata   = bus.i_alu_result;
    assign bus.o_rf_wbe     = we ? lane_en : 4'b0000;
    assign bus.o_done       = done_q;
    assign bus.o_illegal    = illegal_q;
    assign bus.o_vxsat      = vxsat_q;

    // Sticky saturation: set by a saturating op whose written word overflowed; clear wins.
    always_comb begin
        vxsat_d = vxsat_q;
        if (we && funct6_q[5] && !bus.i_alu_is_sat) vxsat_d = 1'b1;
        if (bus.i_vxsat_clr)                         vxsat_d = 1'b0;
    end

    // Saturation flag register.
    always_ff @(posedge i_clk) begin
        if (i_rst) vxsat_q <= 1'b0;
        else       vxsat_q <= vxsat_d;
    end

    // Command FSM: capture on acceptance, alternate READ/EXEC per word, pulse done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    if (accept) begin
                        funct6_q <= bus.i_funct6;
                        vs1_q    <= bus.i_vs1;
                        vs2_q    <= bus.i_vs2;
                        vd_q     <= bus.i_vd;
                        sew_q    <= bus.i_sew;
                        vm_q     <= bus.i_vm;
                        v0_q     <= bus.i_v0;
                        vl_q     <= vl_eff;
                        n_q      <= n_words;
                        k_q      <= '0;
                        ready_q  <= 1'b0;
                        if (bus.i_sew == 2'b11 || n_words == 8'd0) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            illegal_q <= (bus.i_sew == 2'b11);
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (last_word) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                    end else begin
                        state_q <= READ;
                        k_q     <= k_q + WB'(1);
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer with a write/done scoreboard.
// Latency: expected write and done edges are checked cycle-exactly against acceptance.
// Backpressure: the driver waits on o_ready before each command.
module tb_vector_alu_sequencer;
    localparam int VLEN = 128;
    localparam int AW   = 7;

    logic clk;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic          sat_en;
    logic [AW-1:0] sat_addr;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    wbe;
        logic          b8;
        logic          b16;
    } wr_t;

    typedef struct {
        int   cyc;
        logic ill;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    vector_alu_sequencer_if #(.VLEN(VLEN)) bus ();

    vector_alu_sequencer #(.VLEN(VLEN)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edge counter: after active edge n, cyc == n
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rf_val(input logic [AW-1:0] a);
        return 32'h0101_0101 * {25'd0, a} + 32'h1357_0000;
    endfunction

    // register file model: one-cycle read latency
    always @(posedge clk) begin
        bus.i_rs1_data <= rf_val(bus.o_rs1_addr);
        bus.i_rs2_data <= rf_val(bus.o_rs2_addr);
    end

    // ALU model: plain 32-bit add, overflow flagged only on the chosen word
    assign bus.i_alu_result = bus.o_alu_in1 + bus.o_alu_in2;
    assign bus.i_alu_is_sat = !(sat_en && (bus.o_rf_waddr == sat_addr));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: compare every write and every done pulse against the scoreboard
    always @(negedge clk) begin : mon
        wr_t w;
        dn_t d;
        if (bus.o_rf_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(bus.o_rf_waddr), 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("wr_cycle", 32'(cyc + 1), 32'(w.cyc));
                chk("wr_addr",  32'(bus.o_rf_waddr), 32'(w.addr));
                chk("wr_data",  bus.o_rf_wdata, w.data);
                chk("wr_wbe",   32'(bus.o_rf_wbe), 32'(w.wbe));
                chk("alu_8bits",  32'(bus.o_alu_8bits), 32'(w.b8));
                chk("alu_16bits", 32'(bus.o_alu_16bits), 32'(w.b16));
            end
        end
        if (bus.o_done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(bus.o_done), 32'd0);
            end else begin
                d = dq.pop_front();
                chk("done_cycle", 32'(cyc + 1), 32'(d.cyc));
                chk("done_illegal", 32'(bus.o_illegal), 32'(d.ill));
            end
        end
    end

    // issue one command; push hand-computed expectations (wbe nibble per word, 0 = no write)
    task automatic issue(input logic [5:0] f6, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [4:0] vd, input logic [1:0] sew, input logic [7:0] vl,
                         input logic vm, input logic [15:0] v0, input int n, input int nwr,
                         input logic [15:0] wbe_exp, input logic ill, input logic want_done,
                         output int t);
        int  guard;
        wr_t w;
        dn_t d;
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_funct6 = f6;
        bus.i_vs1    = vs1;
        bus.i_vs2    = vs2;
        bus.i_vd     = vd;
        bus.i_sew    = sew;
        bus.i_vl     = vl;
        bus.i_vm     = vm;
        bus.i_v0     = v0;
        guard = 0;
        while (bus.o_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("accept_timeout", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        t = cyc;
        // anything driven after acceptance must be ignored
        bus.i_valid  = 1'b0;
        bus.i_funct6 = 6'($urandom);
        bus.i_vs1    = 5'($urandom);
        bus.i_vs2    = 5'($urandom);
        bus.i_vd     = 5'($urandom);
        bus.i_sew    = 2'($urandom);
        bus.i_vl     = 8'($urandom);
        bus.i_vm     = 1'($urandom);
        bus.i_v0     = 16'($urandom);
        for (int k = 0; k < nwr; k++) begin
            if (wbe_exp[4*k +: 4] != 4'b0000) begin
                w.cyc  = t + 2*k + 2;
                w.addr = {vd, 2'(k)};
                w.data = rf_val({vs2, 2'(k)}) + rf_val({vs1, 2'(k)});
                w.wbe  = wbe_exp[4*k +: 4];
                w.b8   = (sew == 2'b00);
                w.b16  = (sew == 2'b01);
                wq.push_back(w);
            end
        end
        if (want_done) begin
            d.cyc = (n > 0 && !ill) ? (t + 2*n + 1) : (t + 1);
            d.ill = ill;
            dq.push_back(d);
        end
    endtask

    // wait until the edge after o_done, then ready must be back and the scoreboard drained
    task automatic finish_cmd(input int t, input int n, input logic ill);
        int target;
        target = (n > 0 && !ill) ? (t + 2*n + 1) : (t + 1);
        do @(negedge clk); while (cyc < target);
        chk("ready_after_done", 32'(bus.o_ready), 32'd1);
        chk("writes_pending", 32'(wq.size()), 32'd0);
        chk("done_pending", 32'(dq.size()), 32'd0);
    endtask

    initial begin
        int t;
        rst             = 1'b1;
        sat_en          = 1'b0;
        sat_addr        = '0;
        bus.i_valid     = 1'b0;
        bus.i_funct6    = '0;
        bus.i_vs1       = '0;
        bus.i_vs2       = '0;
        bus.i_vd        = '0;
        bus.i_sew       = '0;
        bus.i_vl        = '0;
        bus.i_vm        = 1'b1;
        bus.i_v0        = '0;
        bus.i_vxsat_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   32'(bus.o_ready), 32'd1);
        chk("rst_we",      32'(bus.o_rf_we), 32'd0);
        chk("rst_done",    32'(bus.o_done), 32'd0);
        chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
        chk("rst_vxsat",   32'(bus.o_vxsat), 32'd0);
        rst = 1'b0;

        // vadd SEW8 vl=16: four full words; overflow on word 0 must not set vxsat
        sat_en = 1'b1; sat_addr = {5'd3, 2'd0};
        issue(6'h00, 5'd1, 5'd2, 5'd3, 2'b00, 8'd16, 1'b1, 16'h0000, 4, 4, 16'hFFFF, 1'b0, 1'b1, t);
        finish_cmd(t, 4, 1'b0);
        chk("vxsat_nonsat_op", 32'(bus.o_vxsat), 32'd0);
        sat_en = 1'b0;

        // SEW16 vl=3: word1 only lower half
        issue(6'h00, 5'd4, 5'd5, 5'd6, 2'b01, 8'd3, 1'b1, 16'h0000, 2, 2, 16'h003F, 1'b0, 1'b1, t);
        finish_cmd(t, 2, 1'b0);

        // SEW32 vl=4 masked by v0=0101: words 0 and 2 only
        issue(6'h00, 5'd7, 5'd8, 5'd10, 2'b10, 8'd4, 1'b0, 16'h0005, 4, 4, 16'h0F0F, 1'b0, 1'b1, t);
        finish_cmd(t, 4, 1'b0);

        // SEW8 vl=5 masked by v0=1_1001: word0 lanes 0,3; word1 lane 0
        issue(6'h00, 5'd11, 5'd12, 5'd13, 2'b00, 8'd5, 1'b0, 16'h0019, 2, 2, 16'h0019, 1'b0, 1'b1, t);
        finish_cmd(t, 2, 1'b0);

        // vl clamped to register capacity
        issue(6'h00, 5'd14, 5'd15, 5'd16, 2'b10, 8'd200, 1'b1, 16'h0000, 4, 4, 16'hFFFF, 1'b0, 1'b1, t);
        finish_cmd(t, 4, 1'b0);
        issue(6'h00, 5'd17, 5'd18, 5'd19, 2'b01, 8'd20, 1'b1, 16'h0000, 4, 4, 16'hFFFF, 1'b0, 1'b1, t);
        finish_cmd(t, 4, 1'b0);

        // empty and illegal commands complete immediately without writes
        issue(6'h00, 5'd1, 5'd2, 5'd20, 2'b00, 8'd0, 1'b1, 16'h0000, 0, 0, 16'h0000, 1'b0, 1'b1, t);
        finish_cmd(t, 0, 1'b0);
        issue(6'h00, 5'd1, 5'd2, 5'd21, 2'b11, 8'd5, 1'b1, 16'h0000, 0, 0, 16'h0000, 1'b1, 1'b1, t);
        finish_cmd(t, 0, 1'b1);

        // vsaddu overflowing on word 1: vxsat rises after the word-1 write edge
        sat_en = 1'b1; sat_addr = {5'd22, 2'd1};
        issue(6'b100000, 5'd1, 5'd2, 5'd22, 2'b00, 8'd16, 1'b1, 16'h0000, 4, 4, 16'hFFFF, 1'b0, 1'b1, t);
        do @(negedge clk); while (cyc < t + 3);
        chk("vxsat_before_word1", 32'(bus.o_vxsat), 32'd0);
        @(negedge clk);
        chk("vxsat_after_word1", 32'(bus.o_vxsat), 32'd1);
        finish_cmd(t, 4, 1'b0);
        chk("vxsat_sticky", 32'(bus.o_vxsat), 32'd1);
        @(negedge clk); bus.i_vxsat_clr = 1'b1;
        @(negedge clk); bus.i_vxsat_clr = 1'b0;
        chk("vxsat_cleared", 32'(bus.o_vxsat), 32'd0);

        // clear held while a saturating write overflows: clear wins
        sat_addr = {5'd23, 2'd0};
        bus.i_vxsat_clr = 1'b1;
        issue(6'b100000, 5'd3, 5'd4, 5'd23, 2'b10, 8'd1, 1'b1, 16'h0000, 1, 1, 16'h000F, 1'b0, 1'b1, t);
        do @(negedge clk); while (cyc < t + 2);
        chk("vxsat_clr_priority", 32'(bus.o_vxsat), 32'd0);
        finish_cmd(t, 1, 1'b0);
        bus.i_vxsat_clr = 1'b0;

        // reset during EXEC of word 1 of 4: only word 0 lands, vxsat cleared
        sat_addr = {5'd9, 2'd0};
        issue(6'b100000, 5'd5, 5'd6, 5'd9, 2'b10, 8'd4, 1'b1, 16'h0000, 4, 1, 16'h000F, 1'b0, 1'b0, t);
        repeat (3) @(posedge clk);
        #1;
        chk("vxsat_before_abort", 32'(bus.o_vxsat), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", 32'(bus.o_ready), 32'd1);
        chk("abort_vxsat", 32'(bus.o_vxsat), 32'd0);
        chk("abort_we",    32'(bus.o_rf_we), 32'd0);
        rst    = 1'b0;
        sat_en = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_writes_pending", 32'(wq.size()), 32'd0);
        chk("abort_done_pending",   32'(dq.size()), 32'd0);
        chk("abort_idle_ready",     32'(bus.o_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
